game_seq_ctl: RTL and testbench

- Game sequencer for the falling-cat catch game. It owns the START/PLAY/END state machine, cat spawn position, fall motion, catch/miss decision against the bag, score and lives.
- It sits between the mouse controller (buttons, bag x) and the draw stages. Its outputs drive the cat sprite position, the bag/score display and the state-dependent text.
- It replaces the ad-hoc top-level game logic with a single sequenced block, frame-paced from vsync.

---
 rtl/game_seq_ctl.sv | 223 ++++++++++++++++++++++
 tb/tb_game_seq_ctl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_seq_ctl.sv
// Falling-cat game sequencer: START/PLAY/END control, cat spawn and fall, catch/miss, score and lives.
// Build option: define GAME_SEQ_SPEEDUP_EN to raise the fall step by one every fifth catch.
module game_seq_ctl #(
    parameter int          SCREEN_H       = 600,
    parameter int          BAG_Y          = 530,
    parameter int          BAG_W          = 48,
    parameter int          CAT_W          = 48,
    parameter int          CAT_H          = 64,
    parameter int          X_MIN          = 100,
    parameter int          X_MAX          = 700,
    parameter int          START_SPEED    = 2,
    parameter int          MAX_SPEED      = 8,
    parameter int          LIVES          = 3,
    parameter int          RESPAWN_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        start_btn,
    input  logic        restart_btn,
    input  logic [11:0] bag_xpos,
    output logic [1:0]  state_out,
    output logic [11:0] cat_xpos,
    output logic [11:0] cat_ypos,
    output logic        cat_visible,
    output logic [13:0] score,
    output logic [2:0]  lives_left,
    output logic        caught,
    output logic        missed
);

    localparam int          SPAN      = X_MAX - X_MIN + 1;
    localparam int          SPD_W     = $clog2(MAX_SPEED + 1);
    localparam int          CNT_W     = $clog2(RESPAWN_FRAMES + 1);
    localparam int          INIT_SPD  = (START_SPEED > MAX_SPEED) ? MAX_SPEED : START_SPEED;
    localparam logic [11:0] REST_Y    = 12'(BAG_Y - CAT_H);
    localparam logic [13:0] SCORE_MAX = 14'd9999;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_FALL,
        ST_WAIT,
        ST_OVER
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        state_code_next;
    logic              vsync_d;
    logic              tick;
    logic [15:0]       lfsr;
    logic [9:0]        spawn_off;
    logic [11:0]       spawn_x;
    logic [SPD_W-1:0]  speed;
    logic [CNT_W-1:0]  frame_cnt;
    logic [12:0]       ny;
    logic [12:0]       ny_bottom;
    logic              contact;
    logic              hit;
    logic              wait_done;
    logic              game_start;
    logic              do_catch;
    logic              do_miss;

    always_ff @(posedge pclk) begin
        vsync_d <= vsync_in;
    end

    assign tick = vsync_in & ~vsync_d;

    // Free-running spawn source: keeps stepping in every state so spawn x depends on player timing.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign spawn_off = (lfsr[9:0] > 10'(SPAN - 1)) ? (lfsr[9:0] - 10'(SPAN)) : lfsr[9:0];
    assign spawn_x   = 12'(X_MIN) + {2'b00, spawn_off};

    assign ny         = {1'b0, cat_ypos} + 13'(speed);
    assign ny_bottom  = ny + 13'(CAT_H);
    assign contact    = (ny_bottom >= 13'(BAG_Y)) || (ny_bottom >= 13'(SCREEN_H));
    assign hit        = (({1'b0, cat_xpos} + 13'(CAT_W)) > {1'b0, bag_xpos}) &&
                        (({1'b0, bag_xpos} + 13'(BAG_W)) > {1'b0, cat_xpos});
    assign wait_done  = (frame_cnt == CNT_W'(RESPAWN_FRAMES - 1));
    assign game_start = (state == ST_IDLE) && start_btn;
    assign do_catch   = (state == ST_FALL) && tick && contact && hit;
    assign do_miss    = (state == ST_FALL) && tick && contact && !hit;

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            state_out <= 2'b01;
        end else begin
            state     <= state_next;
            state_out <= state_code_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_btn) state_next = ST_SPAWN;
            ST_SPAWN: state_next = ST_FALL;
            ST_FALL: begin
                if (do_catch) begin
                    state_next = ST_WAIT;
                end else if (do_miss) begin
                    state_next = (lives_left == 3'd1) ? ST_OVER : ST_WAIT;
                end
            end
            ST_WAIT:  if (tick && wait_done) state_next = ST_SPAWN;
            ST_OVER:  if (restart_btn) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The display code is taken from the next state so state_out stays a plain register.
    always_comb begin
        state_code_next = 2'b11;
        case (state_next)
            ST_IDLE: state_code_next = 2'b01;
            ST_OVER: state_code_next = 2'b10;
            default: state_code_next = 2'b11;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            cat_xpos    <= 12'd400;
            cat_ypos    <= '0;
            cat_visible <= 1'b0;
            score       <= '0;
            lives_left  <= 3'(LIVES);
            caught      <= 1'b0;
            missed      <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            caught <= 1'b0;
            missed <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (game_start) begin
                        score      <= '0;
                        lives_left <= 3'(LIVES);
                        frame_cnt  <= '0;
                    end
                end
                ST_SPAWN: begin
                    cat_xpos    <= spawn_x;
                    cat_ypos    <= '0;
                    cat_visible <= 1'b1;
                end
                ST_FALL: begin
                    if (tick) begin
                        if (contact) begin
                            cat_ypos    <= REST_Y;
                            cat_visible <= 1'b0;
                            if (hit) begin
                                caught <= 1'b1;
                                score  <= (score >= SCORE_MAX) ? SCORE_MAX : score + 14'd1;
                            end else begin
                                missed     <= 1'b1;
                                lives_left <= lives_left - 3'd1;
                            end
                        end else begin
                            cat_ypos <= ny[11:0];
                        end
                    end
                end
                ST_WAIT: begin
                    if (tick) begin
                        frame_cnt <= wait_done ? '0 : frame_cnt + 1'b1;
                    end
                end
                ST_OVER: begin
                    cat_visible <= 1'b0;
                    if (restart_btn) begin
                        score      <= '0;
                        lives_left <= 3'(LIVES);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GAME_SEQ_SPEEDUP_EN
    localparam int SPEEDUP_EVERY = 5;
    localparam int MOD_W         = $clog2(SPEEDUP_EVERY);

    logic [MOD_W-1:0] catch_mod;
    logic [SPD_W-1:0] speed_up;

    assign speed_up = (speed >= SPD_W'(MAX_SPEED)) ? SPD_W'(MAX_SPEED) : speed + 1'b1;

    // Catches are counted separately from score so a saturated score still drives speed-up.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            speed     <= SPD_W'(INIT_SPD);
            catch_mod <= '0;
        end else if (game_start) begin
            speed     <= SPD_W'(INIT_SPD);
            catch_mod <= '0;
        end else if (do_catch) begin
            if (catch_mod == MOD_W'(SPEEDUP_EVERY - 1)) begin
                catch_mod <= '0;
                speed     <= speed_up;
            end else begin
                catch_mod <= catch_mod + 1'b1;
            end
        end
    end
`else
    assign speed = SPD_W'(INIT_SPD);
`endif

endmodule

// File: tb/tb_game_seq_ctl.sv
// Randomized self-checking bench for game_seq_ctl, compared every cycle against a frame-level game model.
module tb_game_seq_ctl;

    localparam int P_START = 0, P_SPAWN = 1, P_FALL = 2, P_WAIT = 3, P_OVER = 4;
    localparam int C_FALL = 0, C_CONTACT = 1, C_SPAWN = 2, C_Y200 = 3;

    logic        pclk = 1'b0;
    logic        rst;
    logic        vsync_in;
    logic        start_btn;
    logic        restart_btn;
    logic [11:0] bag_xpos;
    logic [1:0]  state_out;
    logic [11:0] cat_xpos;
    logic [11:0] cat_ypos;
    logic        cat_visible;
    logic [13:0] score;
    logic [2:0]  lives_left;
    logic        caught;
    logic        missed;

    game_seq_ctl dut (
        .pclk        (pclk),
        .rst         (rst),
        .vsync_in    (vsync_in),
        .start_btn   (start_btn),
        .restart_btn (restart_btn),
        .bag_xpos    (bag_xpos),
        .state_out   (state_out),
        .cat_xpos    (cat_xpos),
        .cat_ypos    (cat_ypos),
        .cat_visible (cat_visible),
        .score       (score),
        .lives_left  (lives_left),
        .caught      (caught),
        .missed      (missed)
    );

    always #5 pclk = ~pclk;

    int compared   = 0;
    int mismatched = 0;
    bit cmp_en     = 1'b0;

    int vs_cnt = 0;
    int vs_per = 6;
    int vs_hi  = 1;

    // Game model: positions follow directly from ticks counted since spawn.
    int          m_phase = P_START;
    int          m_x = 400, m_y = 0, m_score = 0, m_lives = 3, m_speed = 2;
    int          m_fall_ticks = 0, m_wait_ticks = 0, m_catches = 0, m_tick_total = 0;
    bit          m_vis = 1'b0, m_caught = 1'b0, m_missed = 1'b0, m_vs_prev = 1'b0;
    logic [15:0] m_lfsr = 16'hACE1;

    function automatic int stateCode(input int ph);
        if (ph == P_START) return 1;
        if (ph == P_OVER) return 2;
        return 3;
    endfunction

    always @(posedge pclk) begin
        bit tk;
        int d;
        tk = vsync_in && !m_vs_prev;
        m_vs_prev = vsync_in;
        m_caught = 1'b0;
        m_missed = 1'b0;
        if (tk) m_tick_total++;
        if (!rst) begin
            m_phase = P_START; m_x = 400; m_y = 0; m_vis = 1'b0;
            m_score = 0; m_lives = 3; m_speed = 2; m_lfsr = 16'hACE1;
            m_fall_ticks = 0; m_wait_ticks = 0; m_catches = 0;
        end else begin
            case (m_phase)
                P_START: if (start_btn) begin
                    m_phase = P_SPAWN; m_score = 0; m_lives = 3; m_speed = 2; m_catches = 0;
                end
                P_SPAWN: begin
                    m_x = 100 + (int'(m_lfsr[9:0]) % 601);
                    m_y = 0; m_vis = 1'b1; m_fall_ticks = 0; m_phase = P_FALL;
                end
                P_FALL: if (tk) begin
                    m_fall_ticks++;
                    if (m_fall_ticks * m_speed + 64 >= 530) begin
                        m_y = 466; m_vis = 1'b0; m_wait_ticks = 0;
                        d = int'(bag_xpos) - m_x;
                        if (d > -48 && d < 48) begin
                            m_caught = 1'b1;
                            m_score = (m_score < 9999) ? m_score + 1 : 9999;
                            m_phase = P_WAIT;
`ifdef GAME_SEQ_SPEEDUP_EN
                            m_catches++;
                            if (m_catches % 5 == 0 && m_speed < 8) m_speed++;
`endif
                        end else begin
                            m_missed = 1'b1;
                            m_lives--;
                            m_phase = (m_lives == 0) ? P_OVER : P_WAIT;
                        end
                    end else begin
                        m_y = m_fall_ticks * m_speed;
                    end
                end
                P_WAIT: if (tk) begin
                    m_wait_ticks++;
                    if (m_wait_ticks == 30) m_phase = P_SPAWN;
                end
                P_OVER: if (restart_btn) begin
                    m_phase = P_START; m_score = 0; m_lives = 3;
                end
                default: ;
            endcase
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    always @(negedge pclk) begin
        if (cmp_en) begin
            compared++;
            if (state_out !== 2'(stateCode(m_phase)) || cat_xpos !== 12'(m_x) ||
                cat_ypos !== 12'(m_y) || cat_visible !== m_vis || score !== 14'(m_score) ||
                lives_left !== 3'(m_lives) || caught !== m_caught || missed !== m_missed) begin
                mismatched++;
                $display("[TB] FAIL cycle_compare t=%0t got st=%b x=%0d y=%0d vis=%b sc=%0d lv=%0d c=%b m=%b required st=%0d x=%0d y=%0d vis=%b sc=%0d lv=%0d c=%b m=%b",
                         $time, state_out, cat_xpos, cat_ypos, cat_visible, score, lives_left, caught, missed,
                         stateCode(m_phase), m_x, m_y, m_vis, m_score, m_lives, m_caught, m_missed);
            end
        end
    end

    task automatic applyStimulus();
        @(negedge pclk);
        vs_cnt++;
        if (vs_cnt >= vs_per) begin
            vs_cnt = 0;
            vs_per = $urandom_range(5, 8);
            vs_hi  = $urandom_range(1, 2);
        end
        vsync_in = (vs_cnt < vs_hi);
        if (m_phase == P_FALL || m_phase == P_WAIT) begin
            start_btn   = 1'($urandom_range(0, 1));
            restart_btn = 1'($urandom_range(0, 1));
        end else begin
            start_btn   = 1'b0;
            restart_btn = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        compared++;
        if (actual !== 32'(expected)) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    function automatic bit condMet(input int c);
        case (c)
            C_FALL:    return m_phase == P_FALL;
            C_CONTACT: return m_caught || m_missed;
            C_SPAWN:   return m_phase == P_SPAWN;
            C_Y200:    return (m_phase == P_FALL) && (m_y >= 200);
            default:   return 1'b1;
        endcase
    endfunction

    task automatic runUntil(input int cond, input string what);
        for (int i = 0; i < 4000; i++) begin
            applyStimulus();
            if (condMet(cond)) return;
        end
        compared++;
        mismatched++;
        $display("[TB] FAIL timeout %s: not reached, required within 4000 cycles", what);
    endtask

    task automatic playCat(input int offset, output int t0);
        runUntil(C_FALL, "cat falling");
        bag_xpos = 12'(m_x + offset);
        compared++;
        if (cat_xpos < 12'd100 || cat_xpos > 12'd700) begin
            mismatched++;
            $display("[TB] FAIL spawn_range: got %0d, required 100..700", cat_xpos);
        end
        t0 = m_tick_total;
        runUntil(C_CONTACT, "cat contact");
    endtask

    initial begin
        int t0;
        int t1;
        rst = 1'b0; vsync_in = 1'b0; start_btn = 1'b0; restart_btn = 1'b0; bag_xpos = '0;
        repeat (3) applyStimulus();
        cmp_en = 1'b1;
        rst = 1'b1;
        repeat (24) applyStimulus();
        checkOutput("idle state_out", state_out, 1);
        checkOutput("idle score", score, 0);
        checkOutput("idle lives", lives_left, 3);
        checkOutput("idle visible", cat_visible, 0);
        checkOutput("idle cat_xpos", cat_xpos, 400);

        start_btn = 1'b1;
        playCat(-20, t0);
        checkOutput("catch tick count", m_tick_total - t0, 233);
        checkOutput("catch pulse", caught, 1);
        checkOutput("catch score", score, 1);
        checkOutput("catch state_out", state_out, 3);
        checkOutput("catch cat_ypos", cat_ypos, 466);
        t1 = m_tick_total;
        applyStimulus();
        checkOutput("catch pulse width", caught, 0);
        runUntil(C_SPAWN, "respawn");
        checkOutput("respawn tick count", m_tick_total - t1, 30);

        playCat(47, t0);
        checkOutput("edge +47 caught", caught, 1);
        playCat(48, t0);
        checkOutput("edge +48 missed", missed, 1);
        checkOutput("edge +48 lives", lives_left, 2);
        playCat(-47, t0);
        checkOutput("edge -47 caught", caught, 1);
        playCat(-48, t0);
        checkOutput("edge -48 missed", missed, 1);
        checkOutput("edge -48 lives", lives_left, 1);
        playCat(300, t0);
        checkOutput("last miss pulse", missed, 1);
        checkOutput("over state_out", state_out, 2);
        checkOutput("over lives", lives_left, 0);
        repeat (10) applyStimulus();
        checkOutput("over score held", score, 3);
        checkOutput("over visible", cat_visible, 0);

        start_btn = 1'b1; restart_btn = 1'b1;
        applyStimulus();
        checkOutput("restart state_out", state_out, 1);
        checkOutput("restart score", score, 0);
        checkOutput("restart lives", lives_left, 3);
        start_btn = 1'b1; restart_btn = 1'b1;
        applyStimulus();
        checkOutput("start after idle", state_out, 3);

        playCat(10, t0);
        playCat(-100, t0);
        runUntil(C_Y200, "mid-fall");
        checkOutput("mid-fall cat_ypos", cat_ypos, 200);
        rst = 1'b0;
        applyStimulus();
        rst = 1'b1;
        checkOutput("abort state_out", state_out, 1);
        checkOutput("abort cat_xpos", cat_xpos, 400);
        checkOutput("abort cat_ypos", cat_ypos, 0);
        checkOutput("abort visible", cat_visible, 0);
        checkOutput("abort score", score, 0);
        checkOutput("abort lives", lives_left, 3);
        checkOutput("abort lfsr", dut.lfsr, 16'hACE1);

        repeat (10) applyStimulus();
        start_btn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            playCat(int'($urandom_range(0, 160)) - 80, t0);
        end
        repeat (5) applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
